// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_unit_pkg;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DRAIN = 2'd2
    } fetchState_t;

    localparam logic [31:0] NOP              = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/fetch_unit_if.sv
// Single-outstanding instruction-memory request/ready handshake.
interface fetch_unit_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              req;
    logic [ADDR_W-1:0] addr;
    logic              ready;
    logic [DATA_W-1:0] rdata;

    modport master (output req, output addr, input ready, input rdata);
    modport slave  (input req, input addr, output ready, output rdata);
endinterface

// File: rtl/fetch_unit_pc_register.sv
// Program counter: sync reset, enable, and a PC+4 / branch-target load mux.
module pc_register
    import fetch_unit_pkg::*;
#(
    parameter int               ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC)
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              enable,
    input  logic              loadTarget,
    input  logic [ADDR_W-1:0] target,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pcPlus4
);

    // Sequential PC never faults on overflow; it wraps modulo 2^ADDR_W.
    assign pcPlus4 = pc + ADDR_W'(4);

    // PC update: reset wins, then redirect target, else sequential advance.
    always_ff @(posedge Clk) begin
        if (Reset)
            pc <= RESET_PC;
        else if (enable)
            pc <= loadTarget ? target : pcPlus4;
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC, IF/ID register, hold buffer and memory handshake.
//
// state | meaning
// FETCH | request outstanding at PC; handoff to IF/ID when data returns
// HOLD  | word fetched but ID stalled; word parked in hold buffer, no request
// DRAIN | redirected while a request was pending; wait out the stale reply
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int               ADDR_W   = 32,
    parameter int               DATA_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC)
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              PCWrite,
    input  logic              IFIDWrite,
    input  logic              BranchTaken,
    input  logic [ADDR_W-1:0] BranchTarget,
    fetch_unit_if.master      imem,
    output logic [DATA_W-1:0] IFID_Instr,
    output logic [ADDR_W-1:0] IFID_PCPlus4,
    output logic              IFID_Valid,
    output logic              FetchStall
);

    fetchState_t       state;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pcPlus4;
    logic [ADDR_W-1:0] drainAddr;
    logic [DATA_W-1:0] holdBuf;
    logic              handoff;
    logic              pcEnable;

    // A mismatched PCWrite/IFIDWrite pair is treated as a full stall.
    assign handoff  = PCWrite & IFIDWrite;
    assign pcEnable = BranchTaken
                    | (handoff & (((state == FETCH) & imem.ready) | (state == HOLD)));

    pc_register #(.ADDR_W(ADDR_W), .RESET_PC(RESET_PC)) pcReg (
        .Clk       (Clk),
        .Reset     (Reset),
        .enable    (pcEnable),
        .loadTarget(BranchTaken),
        .target    (BranchTarget),
        .pc        (pc),
        .pcPlus4   (pcPlus4)
    );

    // DRAIN keeps presenting the abandoned address so the request stays stable.
    assign imem.req   = ~Reset & (state != HOLD);
    assign imem.addr  = (state == DRAIN) ? drainAddr : pc;
    assign FetchStall = ~Reset & ((state == DRAIN) | ((state == FETCH) & ~imem.ready));

    // FSM, hold buffer and IF/ID register; redirect outranks stall and handoff.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state        <= FETCH;
            IFID_Instr   <= DATA_W'(NOP);
            IFID_PCPlus4 <= '0;
            IFID_Valid   <= 1'b0;
            holdBuf      <= DATA_W'(NOP);
            drainAddr    <= RESET_PC;
        end else if (BranchTaken) begin
            IFID_Instr   <= DATA_W'(NOP);
            IFID_PCPlus4 <= '0;
            IFID_Valid   <= 1'b0;
            holdBuf      <= DATA_W'(NOP);
            case (state)
                FETCH: begin
                    if (imem.ready) begin
                        state <= FETCH;
                    end else begin
                        state     <= DRAIN;
                        drainAddr <= pc;
                    end
                end
                HOLD:    state <= FETCH;
                DRAIN:   state <= DRAIN;
                default: state <= FETCH;
            endcase
        end else begin
            case (state)
                FETCH: begin
                    if (imem.ready) begin
                        if (handoff) begin
                            IFID_Instr   <= imem.rdata;
                            IFID_PCPlus4 <= pcPlus4;
                            IFID_Valid   <= 1'b1;
                        end else begin
                            holdBuf <= imem.rdata;
                            state   <= HOLD;
                        end
                    end else if (IFIDWrite) begin
                        IFID_Instr   <= DATA_W'(NOP);
                        IFID_PCPlus4 <= '0;
                        IFID_Valid   <= 1'b0;
                    end
                end
                HOLD: begin
                    if (handoff) begin
                        IFID_Instr   <= holdBuf;
                        IFID_PCPlus4 <= pcPlus4;
                        IFID_Valid   <= 1'b1;
                        state        <= FETCH;
                    end
                end
                DRAIN: begin
                    if (imem.ready)
                        state <= FETCH;
                end
                default: state <= FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit.
module tb_fetch_unit;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        PCWrite;
    logic        IFIDWrite;
    logic        BranchTaken;
    logic [31:0] BranchTarget;
    logic [31:0] IFID_Instr;
    logic [31:0] IFID_PCPlus4;
    logic        IFID_Valid;
    logic        FetchStall;

    int passCnt  = 0;
    int totalCnt = 0;

    fetch_unit_if #(.ADDR_W(32), .DATA_W(32)) imemBus ();

    fetch_unit #(.ADDR_W(32), .DATA_W(32), .RESET_PC(32'h0)) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .PCWrite     (PCWrite),
        .IFIDWrite   (IFIDWrite),
        .BranchTaken (BranchTaken),
        .BranchTarget(BranchTarget),
        .imem        (imemBus),
        .IFID_Instr  (IFID_Instr),
        .IFID_PCPlus4(IFID_PCPlus4),
        .IFID_Valid  (IFID_Valid),
        .FetchStall  (FetchStall)
    );

    // Free-running clock.
    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        totalCnt++;
        assert (obs === exp) passCnt++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Directed stimulus with hand-computed expectations.
    initial begin
        Reset = 1'b1; PCWrite = 1'b1; IFIDWrite = 1'b1;
        BranchTaken = 1'b0; BranchTarget = 32'h0;
        imemBus.ready = 1'b0; imemBus.rdata = 32'h0;

        // 1: reset
        tick();
        check("rst_req", 32'(imemBus.req), 32'h0);
        tick();
        check("rst_req2", 32'(imemBus.req), 32'h0);
        check("rst_valid", 32'(IFID_Valid), 32'h0);
        check("rst_instr", IFID_Instr, 32'h0);
        check("rst_pp4", IFID_PCPlus4, 32'h0);
        Reset = 1'b0;
        #1;
        check("post_rst_req", 32'(imemBus.req), 32'h1);
        check("post_rst_addr", imemBus.addr, 32'h0);

        // 2: streaming
        imemBus.ready = 1'b1; imemBus.rdata = 32'h8C01_0000;
        tick();
        check("s1_instr", IFID_Instr, 32'h8C01_0000);
        check("s1_pp4", IFID_PCPlus4, 32'h4);
        check("s1_valid", 32'(IFID_Valid), 32'h1);
        check("s1_addr", imemBus.addr, 32'h4);
        imemBus.rdata = 32'h0022_1820;
        tick();
        check("s2_instr", IFID_Instr, 32'h0022_1820);
        check("s2_pp4", IFID_PCPlus4, 32'h8);
        check("s2_addr", imemBus.addr, 32'h8);

        // 3: stall with ready at PC=8 -> HOLD
        imemBus.rdata = 32'hAC03_0008; PCWrite = 1'b0; IFIDWrite = 1'b0;
        check("h_stall_pre", 32'(FetchStall), 32'h0);
        tick();
        check("h1_req", 32'(imemBus.req), 32'h0);
        check("h1_instr", IFID_Instr, 32'h0022_1820);
        check("h1_pp4", IFID_PCPlus4, 32'h8);
        imemBus.rdata = 32'hDEAD_BEEF;
        tick();
        check("h2_req", 32'(imemBus.req), 32'h0);
        check("h2_instr", IFID_Instr, 32'h0022_1820);
        PCWrite = 1'b1; IFIDWrite = 1'b1;
        tick();
        check("h3_instr", IFID_Instr, 32'hAC03_0008);
        check("h3_pp4", IFID_PCPlus4, 32'hC);
        check("h3_valid", 32'(IFID_Valid), 32'h1);
        check("h3_addr", imemBus.addr, 32'hC);
        check("h3_req", 32'(imemBus.req), 32'h1);
        imemBus.rdata = 32'h0123_4567;
        tick();
        check("a10_addr", imemBus.addr, 32'h10);

        // 4: memory wait at 0x10
        imemBus.ready = 1'b0;
        #1;
        check("w0_stall", 32'(FetchStall), 32'h1);
        tick();
        check("w1_valid", 32'(IFID_Valid), 32'h0);
        check("w1_addr", imemBus.addr, 32'h10);
        check("w1_stall", 32'(FetchStall), 32'h1);
        tick();
        check("w2_valid", 32'(IFID_Valid), 32'h0);
        check("w2_addr", imemBus.addr, 32'h10);
        imemBus.ready = 1'b1; imemBus.rdata = 32'h1111_2222;
        tick();
        check("w3_pp4", IFID_PCPlus4, 32'h14);
        check("w3_instr", IFID_Instr, 32'h1111_2222);
        check("w3_addr", imemBus.addr, 32'h14);

        // 5: redirect back to 0x10 (ready=1), then branch while waiting -> DRAIN
        BranchTaken = 1'b1; BranchTarget = 32'h10;
        tick();
        check("b10_valid", 32'(IFID_Valid), 32'h0);
        check("b10_addr", imemBus.addr, 32'h10);
        BranchTaken = 1'b0; imemBus.ready = 1'b0;
        tick();
        check("d0_addr", imemBus.addr, 32'h10);
        BranchTaken = 1'b1; BranchTarget = 32'h40;
        tick();
        check("d1_addr", imemBus.addr, 32'h10);
        check("d1_req", 32'(imemBus.req), 32'h1);
        check("d1_stall", 32'(FetchStall), 32'h1);
        check("d1_valid", 32'(IFID_Valid), 32'h0);
        BranchTaken = 1'b0;
        tick();
        check("d2_addr", imemBus.addr, 32'h10);
        imemBus.ready = 1'b1; imemBus.rdata = 32'hBADB_AD00;
        #1;
        check("d3_stall", 32'(FetchStall), 32'h1);
        tick();
        check("d3_valid", 32'(IFID_Valid), 32'h0);
        check("d3_instr", IFID_Instr, 32'h0);
        check("d3_addr", imemBus.addr, 32'h40);

        // 6: redirect beats stall; PC wrap
        imemBus.rdata = 32'h0000_0055;
        tick();
        check("f40_pp4", IFID_PCPlus4, 32'h44);
        check("f40_valid", 32'(IFID_Valid), 32'h1);
        BranchTaken = 1'b1; BranchTarget = 32'h80; PCWrite = 1'b0; IFIDWrite = 1'b0;
        tick();
        check("b80_valid", 32'(IFID_Valid), 32'h0);
        check("b80_instr", IFID_Instr, 32'h0);
        check("b80_addr", imemBus.addr, 32'h80);
        check("b80_req", 32'(imemBus.req), 32'h1);
        PCWrite = 1'b1; IFIDWrite = 1'b1; BranchTarget = 32'hFFFF_FFFC;
        tick();
        check("bfc_addr", imemBus.addr, 32'hFFFF_FFFC);
        BranchTaken = 1'b0; imemBus.rdata = 32'h0000_0077;
        tick();
        check("wrap_pp4", IFID_PCPlus4, 32'h0);
        check("wrap_instr", IFID_Instr, 32'h77);
        check("wrap_addr", imemBus.addr, 32'h0);

        // Reset while draining abandons the request
        imemBus.ready = 1'b0; BranchTaken = 1'b1; BranchTarget = 32'h100;
        tick();
        BranchTaken = 1'b0; Reset = 1'b1;
        #1;
        check("rd_req", 32'(imemBus.req), 32'h0);
        tick();
        Reset = 1'b0;
        #1;
        check("rd_addr", imemBus.addr, 32'h0);
        imemBus.ready = 1'b1; imemBus.rdata = 32'h0000_0099;
        tick();
        check("rd_instr", IFID_Instr, 32'h99);
        check("rd_pp4", IFID_PCPlus4, 32'h4);

        // Mismatched stall pair (PCWrite=1, IFIDWrite=0) also parks in HOLD
        IFIDWrite = 1'b0; imemBus.rdata = 32'h0000_00AA;
        tick();
        check("mm_req", 32'(imemBus.req), 32'h0);
        check("mm_pp4", IFID_PCPlus4, 32'h4);
        IFIDWrite = 1'b1;
        tick();
        check("mm_instr", IFID_Instr, 32'hAA);
        check("mm_pp4b", IFID_PCPlus4, 32'h8);
        check("mm_addr", imemBus.addr, 32'h8);

        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule
